// File: rtl/runner_pkg.sv
// runner_pkg: shared types for the runner datapath and its game sequencer.
package runner_pkg;
    localparam int SCORE_W = 16;
    typedef logic [SCORE_W-1:0] score_t;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RUNNING = 2'd2,
        CRASHED = 2'd3
    } game_state_t;
    function automatic score_t sat_inc(input score_t s);
        return (&s) ? s : s + 1'b1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter, debounced level and rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic sync1_q, sync2_q, level_q, rise_q, flip;
    logic [CW-1:0] cnt_q;
    // the level flips only once the input has disagreed for the full window
    assign flip = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= (sync2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
            level_q <= flip ? sync2_q : level_q;
            rise_q  <= flip && sync2_q;
        end
    end
    assign level_o = level_q;
    assign rise_o  = rise_q;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame strobe generation, button conditioning and the game-state machine
// feeding the runner (reset, update, jump/duck requests, score).
module game_ctrl
    import runner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int FRAME_DIV         = 1,
    parameter int CRASH_HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        btn_jump,
    input  logic        btn_duck,
    input  logic        crash,
    output logic        update,
    output logic        runner_rst,
    output logic        jumping,
    output logic        ducking,
    output game_state_t state,
    output score_t      score
);
    localparam int HW = $clog2(CRASH_HOLD_FRAMES + 2);
    logic vs1_q, vs2_q, vs3_q, tick_q;
    logic [7:0] div_q;
    logic [HW-1:0] hold_q;
    game_state_t state_q, state_d;
    logic update_q, runner_rst_q, jumping_q, ducking_q;
    score_t score_q;
    logic jump_lvl, jump_rise, duck_lvl, duck_rise_unused;
    logic div_tick, hold_done, update_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_jump), .level_o(jump_lvl), .rise_o(jump_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_duck (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_duck), .level_o(duck_lvl), .rise_o(duck_rise_unused)
    );

    assign div_tick  = tick_q && (div_q == 8'(FRAME_DIV - 1));
    assign hold_done = hold_q == HW'(CRASH_HOLD_FRAMES);
    // a crash in the same cycle as a divided tick suppresses the update
    assign update_d  = (state_q == RUNNING) && div_tick && !crash;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = jump_rise ? START : IDLE;
            START:   state_d = RUNNING;
            RUNNING: state_d = crash ? CRASHED : RUNNING;
            CRASHED: state_d = (jump_rise && hold_done) ? START : CRASHED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs1_q        <= 1'b0;
            vs2_q        <= 1'b0;
            vs3_q        <= 1'b0;
            tick_q       <= 1'b0;
            div_q        <= '0;
            hold_q       <= '0;
            state_q      <= IDLE;
            update_q     <= 1'b0;
            runner_rst_q <= 1'b1;
            jumping_q    <= 1'b0;
            ducking_q    <= 1'b0;
            score_q      <= '0;
        end else begin
            vs1_q        <= vsync;
            vs2_q        <= vs1_q;
            vs3_q        <= vs2_q;
            tick_q       <= vs2_q && !vs3_q;
            div_q        <= (state_q == START || div_tick) ? '0 : tick_q ? div_q + 1'b1 : div_q;
            hold_q       <= (state_q != CRASHED) ? '0 : (tick_q && !hold_done) ? hold_q + 1'b1 : hold_q;
            state_q      <= state_d;
            update_q     <= update_d;
            runner_rst_q <= state_d == START;
            jumping_q    <= jump_lvl && state_d == RUNNING;
            ducking_q    <= duck_lvl && !jump_lvl && state_d == RUNNING;
            score_q      <= (state_d == START) ? '0 : update_d ? sat_inc(score_q) : score_q;
        end
    end

    assign update     = update_q;
    assign runner_rst = runner_rst_q;
    assign jumping    = jumping_q;
    assign ducking    = ducking_q;
    assign state      = state_q;
    assign score      = score_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed, table-driven checks of game_ctrl with FRAME_DIV 1 and 3 instances.
module tb_game_ctrl;
    import runner_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, btn_jump = 1'b0, btn_duck = 1'b0, crash = 1'b0;
    logic update, runner_rst, jumping, ducking;
    logic update3, runner_rst3, jumping3, ducking3;
    game_state_t state, state3;
    score_t score, score3;
    int n_chk = 0, n_fail = 0, ups = 0, ups3 = 0, n = 0;

    always #5 clk = ~clk;

    game_ctrl #(.DEBOUNCE_CYCLES(16), .FRAME_DIV(1), .CRASH_HOLD_FRAMES(30)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .btn_jump(btn_jump), .btn_duck(btn_duck),
        .crash(crash), .update(update), .runner_rst(runner_rst), .jumping(jumping),
        .ducking(ducking), .state(state), .score(score)
    );
    game_ctrl #(.DEBOUNCE_CYCLES(16), .FRAME_DIV(3), .CRASH_HOLD_FRAMES(30)) dut3 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .btn_jump(btn_jump), .btn_duck(btn_duck),
        .crash(crash), .update(update3), .runner_rst(runner_rst3), .jumping(jumping3),
        .ducking(ducking3), .state(state3), .score(score3)
    );

    typedef struct {
        logic jump;
        logic duck;
        int   cyc;
        logic exp_j;
        logic exp_d;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ups  += int'(update);
        ups3 += int'(update3);
    endtask

    task automatic pulse();
        vsync = 1'b1;
        repeat (6) tick();
        vsync = 1'b0;
        repeat (6) tick();
    endtask

    task automatic press();
        btn_jump = 1'b1;
        repeat (25) tick();
        btn_jump = 1'b0;
        repeat (25) tick();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 25, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1,  5, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 25, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 25, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 18, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1,  2, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 25, 1'b0, 1'b0};

        repeat (5) tick();
        chk("rst_runner_rst", int'(runner_rst), 1);
        chk("rst_state", int'(state), int'(IDLE));
        chk("rst_score", int'(score), 0);
        chk("rst_update", int'(update), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_runner_rst", int'(runner_rst), 0);
        ups = 0;
        pulse();
        chk("idle_no_update", ups, 0);
        chk("idle_state", int'(state), int'(IDLE));

        btn_jump = 1'b1;
        n = 0;
        while (state == IDLE && n < 40) begin
            tick();
            n++;
        end
        chk("start_latency", n, 20);
        chk("start_state", int'(state), int'(START));
        chk("start_runner_rst", int'(runner_rst), 1);
        chk("start_jumping", int'(jumping), 0);
        chk("start_score", int'(score), 0);
        tick();
        chk("run_state", int'(state), int'(RUNNING));
        chk("run_runner_rst", int'(runner_rst), 0);
        chk("run_jumping", int'(jumping), 1);
        chk("run_state3", int'(state3), int'(RUNNING));

        ups = 0;
        vsync = 1'b1;
        repeat (3) tick();
        chk("vs_n2_update", int'(update), 0);
        tick();
        chk("vs_n3_update", int'(update), 1);
        chk("score_1", int'(score), 1);
        tick();
        chk("vs_n4_update", int'(update), 0);
        vsync = 1'b0;
        repeat (6) tick();
        chk("single_update", ups, 1);
        for (int i = 2; i <= 3; i++) begin
            pulse();
            chk("score_count", int'(score), i);
        end

        for (int i = 0; i < 7; i++) begin
            btn_jump = vecs[i].jump;
            btn_duck = vecs[i].duck;
            repeat (vecs[i].cyc) tick();
            chk($sformatf("vec%0d_jumping", i), int'(jumping), int'(vecs[i].exp_j));
            chk($sformatf("vec%0d_ducking", i), int'(ducking), int'(vecs[i].exp_d));
            chk($sformatf("vec%0d_jumping3", i), int'(jumping3), int'(vecs[i].exp_j));
            chk($sformatf("vec%0d_ducking3", i), int'(ducking3), int'(vecs[i].exp_d));
            chk($sformatf("vec%0d_state", i), int'(state), int'(RUNNING));
        end

        vsync = 1'b1;
        repeat (3) tick();
        crash = 1'b1;
        tick();
        crash = 1'b0;
        chk("crash_no_update", int'(update), 0);
        chk("crash_state", int'(state), int'(CRASHED));
        vsync = 1'b0;
        repeat (6) tick();
        repeat (10) pulse();
        chk("score_frozen", int'(score), 3);
        press();
        chk("press_at_10", int'(state), int'(CRASHED));
        repeat (19) pulse();
        press();
        chk("press_at_29", int'(state), int'(CRASHED));
        pulse();
        btn_jump = 1'b1;
        n = 0;
        while (state == CRASHED && n < 40) begin
            tick();
            n++;
        end
        chk("restart_state", int'(state), int'(START));
        chk("restart_runner_rst", int'(runner_rst), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_state3", int'(state3), int'(START));
        chk("restart_runner_rst3", int'(runner_rst3), 1);
        tick();
        btn_jump = 1'b0;
        chk("restart_run", int'(state), int'(RUNNING));
        repeat (25) tick();

        ups = 0;
        ups3 = 0;
        repeat (9) pulse();
        chk("div1_updates", ups, 9);
        chk("div3_updates", ups3, 3);
        chk("div1_score", int'(score), 9);
        chk("div3_score", int'(score3), 3);

        force dut.score_q = 16'hFFFD;
        tick();
        release dut.score_q;
        repeat (3) pulse();
        chk("score_saturate", int'(score), 16'hFFFF);

        rst_n = 1'b0;
        tick();
        chk("midreset_state", int'(state), int'(IDLE));
        chk("midreset_runner_rst", int'(runner_rst), 1);
        chk("midreset_score", int'(score), 0);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
